// File: rtl/qdr_seq_pkg.sv
// Shared state encoding and counter sizing for the QDR clock/reset sequencer.
package qdr_seq_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    STABLE    = 3'd3,
    CTRL_RST  = 3'd4,
    READY     = 3'd5,
    FAIL      = 3'd6
  } chan_state_t;

  // One counter serves every timed state, so it must hold the longest interval.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/qdr_clk_rst_chan.sv
// One channel: lock synchronizer, bring-up FSM with shared interval counter,
// retry tracking and saturating lock-loss counter.
module qdr_clk_rst_chan
  import qdr_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int LOCK_STABLE     = 1024,
  parameter int CTRL_RST_CYCLES = 64,
  parameter int RETRY_LIMIT     = 3,
  parameter int LOSS_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_chan_en,
  input  logic              i_pll_lock,
  output logic              o_pll_rst,
  output logic              o_qdr_rst,
  output logic              o_chan_ready,
  output logic              o_chan_fail,
  output logic [LOSS_W-1:0] o_loss_count
);

  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, CTRL_RST_CYCLES);
  localparam int RW = (RETRY_LIMIT < 2) ? 1 : $clog2(RETRY_LIMIT + 1);

  localparam logic [CW-1:0] PLL_LAST  = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] CTRL_LAST = CW'(CTRL_RST_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(RETRY_LIMIT);

  chan_state_t       r_state;
  logic [1:0]        r_sync;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_retry;
  logic [LOSS_W-1:0] r_loss;
  logic              r_pll_rst;
  logic              r_qdr_rst;
  logic              r_ready;
  logic              r_fail;

  logic              w_lock_s;
  logic [RW-1:0]     w_retry_inc;

  assign w_lock_s    = r_sync[1];
  assign w_retry_inc = r_retry + RW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sync    <= '0;
      r_cnt     <= '0;
      r_retry   <= '0;
      r_loss    <= '0;
      r_pll_rst <= 1'b1;
      r_qdr_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_pll_lock};

      // Outputs decode the current state, so they trail each transition by one cycle.
      r_pll_rst <= (r_state == IDLE) || (r_state == PLL_RST) || (r_state == FAIL);
      r_qdr_rst <= (r_state != READY);
      r_ready   <= (r_state == READY);
      r_fail    <= (r_state == FAIL);

      if (!i_chan_en) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_retry <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= PLL_RST;
            r_cnt   <= '0;
            r_retry <= '0;
          end
          PLL_RST: begin
            if (r_cnt == PLL_LAST) begin
              r_state <= WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          WAIT_LOCK: begin
            if (w_lock_s) begin
              // The sample that ended the wait is the first stable cycle.
              r_state <= STABLE;
              r_cnt   <= CW'(1);
            end else if (r_cnt == TO_LAST) begin
              r_retry <= w_retry_inc;
              r_state <= (w_retry_inc == RETRY_MAX) ? FAIL : PLL_RST;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          STABLE: begin
            if (!w_lock_s) begin
              r_state <= WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt >= STB_LAST) begin
              r_state <= CTRL_RST;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          CTRL_RST: begin
            if (!w_lock_s) begin
              r_state <= PLL_RST;
              r_cnt   <= '0;
              if (r_loss != '1) r_loss <= r_loss + LOSS_W'(1);
            end else if (r_cnt == CTRL_LAST) begin
              r_state <= READY;
              r_cnt   <= '0;
              r_retry <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          READY: begin
            if (!w_lock_s) begin
              r_state <= PLL_RST;
              r_cnt   <= '0;
              if (r_loss != '1) r_loss <= r_loss + LOSS_W'(1);
            end
          end
          FAIL: begin
            r_state <= FAIL;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign o_pll_rst    = r_pll_rst;
  assign o_qdr_rst    = r_qdr_rst;
  assign o_chan_ready = r_ready;
  assign o_chan_fail  = r_fail;
  assign o_loss_count = r_loss;

endmodule

// File: rtl/qdr_clk_rst_seq.sv
// Multi-channel QDR clock/reset sequencer: one independent channel sequencer
// per QDR interface plus a registered all-ready summary.
module qdr_clk_rst_seq
  import qdr_seq_pkg::*;
#(
  parameter int NUM_CH          = 2,
  parameter int PLL_RST_CYCLES  = 16,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int LOCK_STABLE     = 1024,
  parameter int CTRL_RST_CYCLES = 64,
  parameter int RETRY_LIMIT     = 3,
  parameter int LOSS_W          = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        chan_en,
  input  logic [NUM_CH-1:0]        pll_lock,
  output logic [NUM_CH-1:0]        pll_rst,
  output logic [NUM_CH-1:0]        qdr_rst,
  output logic [NUM_CH-1:0]        chan_ready,
  output logic [NUM_CH-1:0]        chan_fail,
  output logic [NUM_CH*LOSS_W-1:0] loss_count,
  output logic                     all_ready
);

  logic r_all_ready;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      qdr_clk_rst_chan #(
        .PLL_RST_CYCLES (PLL_RST_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .LOCK_STABLE    (LOCK_STABLE),
        .CTRL_RST_CYCLES(CTRL_RST_CYCLES),
        .RETRY_LIMIT    (RETRY_LIMIT),
        .LOSS_W         (LOSS_W)
      ) u_chan (
        .clk         (clk),
        .reset       (reset),
        .i_chan_en   (chan_en[gi]),
        .i_pll_lock  (pll_lock[gi]),
        .o_pll_rst   (pll_rst[gi]),
        .o_qdr_rst   (qdr_rst[gi]),
        .o_chan_ready(chan_ready[gi]),
        .o_chan_fail (chan_fail[gi]),
        .o_loss_count(loss_count[gi*LOSS_W +: LOSS_W])
      );
    end
  endgenerate

  // Disabled channels are ignored; with nothing enabled the system is not ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_all_ready <= 1'b0;
    end else begin
      r_all_ready <= (|chan_en) && (&(chan_ready | ~chan_en));
    end
  end

  assign all_ready = r_all_ready;

endmodule

// File: tb/tb_qdr_clk_rst_seq.sv
// Directed bench for qdr_clk_rst_seq: bring-up, READY loss, STABLE glitch,
// timeout/fail, loss saturation and reset during controller reset.
module tb_qdr_clk_rst_seq;

  localparam int NUM_CH = 2;
  localparam int LW     = 2;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_CH-1:0]    chan_en;
  logic [NUM_CH-1:0]    pll_lock;
  logic [NUM_CH-1:0]    pll_rst;
  logic [NUM_CH-1:0]    qdr_rst;
  logic [NUM_CH-1:0]    chan_ready;
  logic [NUM_CH-1:0]    chan_fail;
  logic [NUM_CH*LW-1:0] loss_count;
  logic                 all_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  qdr_clk_rst_seq #(
    .NUM_CH         (NUM_CH),
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .LOCK_STABLE    (8),
    .CTRL_RST_CYCLES(4),
    .RETRY_LIMIT    (3),
    .LOSS_W         (LW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .chan_en   (chan_en),
    .pll_lock  (pll_lock),
    .pll_rst   (pll_rst),
    .qdr_rst   (qdr_rst),
    .chan_ready(chan_ready),
    .chan_fail (chan_fail),
    .loss_count(loss_count),
    .all_ready (all_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ch1_ready(input string tag);
    int n;
    n = 0;
    while (chan_ready[1] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (chan_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_timeout got=%b exp=1", tag, chan_ready[1]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; chan_en = 2'b00; pll_lock = 2'b00;
    repeat (3) tick();
    checks++;
    if ({pll_rst, qdr_rst} !== 4'b1111) begin
      errors++; $display("FAIL reset_rst got=%b exp=1111", {pll_rst, qdr_rst});
    end
    checks++;
    if ({chan_ready, chan_fail, loss_count, all_ready} !== 9'd0) begin
      errors++; $display("FAIL reset_status got=%b exp=0", {chan_ready, chan_fail, loss_count, all_ready});
    end
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({pll_rst, qdr_rst, all_ready} !== 5'b11110) begin
      errors++; $display("FAIL idle_disabled got=%b exp=11110", {pll_rst, qdr_rst, all_ready});
    end
  endtask

  task automatic test_bringup();
    chan_en = 2'b11;
    repeat (5) tick();
    checks++;
    if (pll_rst !== 2'b11) begin
      errors++; $display("FAIL bringup_pll_rst_held got=%b exp=11", pll_rst);
    end
    tick();
    checks++;
    if (pll_rst !== 2'b00) begin
      errors++; $display("FAIL bringup_pll_rst_release got=%b exp=00", pll_rst);
    end
    repeat (10) tick();
    pll_lock = 2'b11;
    // 2 sync + 8 stable samples + 4 ctrl reset + 1 output register = 15
    repeat (14) tick();
    checks++;
    if ({chan_ready, qdr_rst} !== 4'b0011) begin
      errors++; $display("FAIL bringup_early got=%b exp=0011", {chan_ready, qdr_rst});
    end
    tick();
    checks++;
    if ({chan_ready, qdr_rst, all_ready} !== 5'b11000) begin
      errors++; $display("FAIL bringup_ready got=%b exp=11000", {chan_ready, qdr_rst, all_ready});
    end
    tick();
    checks++;
    if (all_ready !== 1'b1) begin
      errors++; $display("FAIL bringup_all_ready got=%b exp=1", all_ready);
    end
  endtask

  task automatic test_loss_ready();
    pll_lock[1] = 1'b0;
    repeat (3) tick();
    checks++;
    if ({chan_ready, loss_count} !== 6'b11_0100) begin
      errors++; $display("FAIL loss_count_edge got=%b exp=110100", {chan_ready, loss_count});
    end
    tick();
    checks++;
    if ({chan_ready, qdr_rst, pll_rst, all_ready} !== 7'b01_10_10_1) begin
      errors++; $display("FAIL loss_outputs got=%b exp=0110101", {chan_ready, qdr_rst, pll_rst, all_ready});
    end
    tick();
    checks++;
    if ({all_ready, chan_ready[0], loss_count[1:0]} !== 4'b0100) begin
      errors++; $display("FAIL loss_all_ready got=%b exp=0100", {all_ready, chan_ready[0], loss_count[1:0]});
    end
    pll_lock[1] = 1'b1;
    wait_ch1_ready("loss_resequence");
    tick();
    checks++;
    if ({all_ready, loss_count} !== 5'b1_0100) begin
      errors++; $display("FAIL loss_recovered got=%b exp=10100", {all_ready, loss_count});
    end
  endtask

  task automatic test_glitch();
    chan_en = 2'b01; pll_lock[1] = 1'b0;
    repeat (3) tick();
    chan_en = 2'b11;
    repeat (6) tick();
    checks++;
    if (pll_rst[1] !== 1'b0) begin
      errors++; $display("FAIL glitch_pll_release got=%b exp=0", pll_rst[1]);
    end
    pll_lock[1] = 1'b1;
    repeat (5) tick();
    pll_lock[1] = 1'b0;
    tick();
    pll_lock[1] = 1'b1;
    repeat (9) tick();
    checks++;
    if ({chan_ready[1], qdr_rst[1]} !== 2'b01) begin
      errors++; $display("FAIL glitch_nominal_time got=%b exp=01", {chan_ready[1], qdr_rst[1]});
    end
    repeat (5) tick();
    checks++;
    if (chan_ready[1] !== 1'b0) begin
      errors++; $display("FAIL glitch_early got=%b exp=0", chan_ready[1]);
    end
    tick();
    checks++;
    if ({chan_ready[1], loss_count[3:2]} !== 3'b1_01) begin
      errors++; $display("FAIL glitch_ready got=%b exp=101", {chan_ready[1], loss_count[3:2]});
    end
  endtask

  task automatic test_timeout_fail();
    int cyc, falls, width, w2, w3;
    logic prev;
    chan_en = 2'b01; pll_lock[1] = 1'b0;
    repeat (3) tick();
    chan_en = 2'b11;
    cyc = 0; falls = 0; width = 0; w2 = 0; w3 = 0; prev = 1'b1;
    while (chan_fail[1] !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
      if (pll_rst[1] === 1'b1) begin
        width++;
      end else begin
        if (prev === 1'b1) begin
          falls++;
          if (falls == 2) w2 = width;
          if (falls == 3) w3 = width;
        end
        width = 0;
      end
      prev = pll_rst[1];
    end
    checks++;
    if (cyc != 74) begin
      errors++; $display("FAIL fail_time got=%0d exp=74", cyc);
    end
    checks++;
    if (falls != 3 || w2 != 4 || w3 != 4) begin
      errors++; $display("FAIL fail_pulses got=%0d/%0d/%0d exp=3/4/4", falls, w2, w3);
    end
    repeat (30) tick();
    checks++;
    if ({pll_rst[1], qdr_rst[1], chan_fail[1], chan_ready[0]} !== 4'b1111) begin
      errors++; $display("FAIL fail_sticky got=%b exp=1111", {pll_rst[1], qdr_rst[1], chan_fail[1], chan_ready[0]});
    end
    chan_en = 2'b01;
    repeat (2) tick();
    checks++;
    if (chan_fail[1] !== 1'b0) begin
      errors++; $display("FAIL fail_clear got=%b exp=0", chan_fail[1]);
    end
    chan_en = 2'b11;
    repeat (6) tick();
    checks++;
    if (pll_rst[1] !== 1'b0) begin
      errors++; $display("FAIL fail_restart got=%b exp=0", pll_rst[1]);
    end
  endtask

  task automatic test_saturation();
    logic [LW-1:0] exp_loss;
    exp_loss = 2'd1;
    pll_lock[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_ch1_ready("sat");
      pll_lock[1] = 1'b0;
      repeat (4) tick();
      exp_loss = (exp_loss == 2'd3) ? 2'd3 : exp_loss + 2'd1;
      checks++;
      if (loss_count[3:2] !== exp_loss) begin
        errors++; $display("FAIL sat_loss%0d got=%0d exp=%0d", i, loss_count[3:2], exp_loss);
      end
      pll_lock[1] = 1'b1;
    end
    checks++;
    if (loss_count !== 4'b1100) begin
      errors++; $display("FAIL sat_final got=%b exp=1100", loss_count);
    end
  endtask

  task automatic test_reset_mid();
    wait_ch1_ready("mid");
    chan_en = 2'b01;
    repeat (3) tick();
    chan_en = 2'b11;
    repeat (15) tick();
    checks++;
    if ({pll_rst[1], qdr_rst[1], chan_ready[1]} !== 3'b010) begin
      errors++; $display("FAIL mid_in_ctrl_rst got=%b exp=010", {pll_rst[1], qdr_rst[1], chan_ready[1]});
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({pll_rst, qdr_rst, chan_ready, chan_fail, loss_count, all_ready} !== 13'b1111_0000_0000_0) begin
      errors++; $display("FAIL mid_reset got=%b exp=1111000000000", {pll_rst, qdr_rst, chan_ready, chan_fail, loss_count, all_ready});
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (pll_rst !== 2'b11) begin
      errors++; $display("FAIL mid_idle_restart got=%b exp=11", pll_rst);
    end
    tick();
    checks++;
    if (pll_rst !== 2'b00) begin
      errors++; $display("FAIL mid_restart_release got=%b exp=00", pll_rst);
    end
  endtask

  initial begin
    reset = 1'b1; chan_en = 2'b00; pll_lock = 2'b00;
    test_reset();
    $display("transaction reset done");
    test_bringup();
    $display("transaction bringup done");
    test_loss_ready();
    $display("transaction loss_ready done");
    test_glitch();
    $display("transaction glitch done");
    test_timeout_fail();
    $display("transaction timeout_fail done");
    test_saturation();
    $display("transaction saturation done");
    test_reset_mid();
    $display("transaction reset_mid done");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qdr_clk_rst_seq.md
Name: qdr_clk_rst_seq

Overview:
- Per-channel clock/reset sequencer for multi-channel QDR infrastructure.
- Drives one PLL reset per channel and watches its lock output, with retry on lock timeout.
- Releases each QDR controller reset only after its lock has been stable for a programmable time.
- Counts lock-loss events; generalises single-PLL, lock-only bring-up to N channels with timeout, retry, fail and debounce behaviour.

Parameters:
- NUM_CH, 2, number of QDR channels (1..8).
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt.
- LOCK_TIMEOUT, 65535, cycles to wait for lock before retry.
- LOCK_STABLE, 1024, consecutive locked cycles required before controller reset sequencing.
- CTRL_RST_CYCLES, 64, cycles qdr_rst is held after stable lock.
- RETRY_LIMIT, 3, failed lock attempts before FAIL.
- LOSS_W, 8, width of per-channel saturating lock-loss counter.

Ports:
- clk  in  1  sequencer clock, free-running, independent of the PLLs.
- reset  in  1  synchronous, active-high.
- chan_en  in  NUM_CH  per-channel enable, synchronous to clk.
- pll_lock  in  NUM_CH  PLL LOCKED outputs, asynchronous to clk.
- pll_rst  out  NUM_CH  PLL reset.
- qdr_rst  out  NUM_CH  QDR controller reset.
- chan_ready  out  NUM_CH  channel clocks good and controller released.
- chan_fail  out  NUM_CH  retry limit exhausted (sticky).
- loss_count  out  NUM_CH*LOSS_W  per-channel lock-loss count; channel i occupies bits [i*LOSS_W +: LOSS_W].
- all_ready  out  1  AND of chan_ready over enabled channels; 0 if no channel is enabled.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high.
- Each pll_lock bit passes through a 2-flop synchronizer (lock_s). The FSM uses only lock_s.
- Reset values: pll_rst=all 1, qdr_rst=all 1, chan_ready=0, chan_fail=0, loss_count=0, all_ready=0, every FSM in IDLE, all counters 0.
- Outputs are registered and take effect the cycle after the state change.
- Per-channel FSM states and transitions:
  - IDLE: pll_rst=1, qdr_rst=1. Goes to PLL_RST when chan_en=1.
  - PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK with the timeout counter cleared.
  - WAIT_LOCK: pll_rst=0.
    - lock_s=1 -> STABLE.
    - Counter reaches LOCK_TIMEOUT-1 -> retry_cnt+1. If the new retry_cnt equals RETRY_LIMIT -> FAIL, otherwise -> PLL_RST.
  - STABLE: counts consecutive lock_s=1 cycles.
    - lock_s=0 -> WAIT_LOCK; timeout counter restarts; no retry increment; no loss count.
    - Count reaches LOCK_STABLE -> CTRL_RST.
  - CTRL_RST: qdr_rst=1 for CTRL_RST_CYCLES cycles, then READY.
    - lock_s=0 -> PLL_RST and loss_count+1.
  - READY: qdr_rst=0, chan_ready=1, retry_cnt cleared on entry.
    - lock_s=0 -> PLL_RST and loss_count+1. chan_ready and qdr_rst change on the next cycle.
  - FAIL: pll_rst=1, qdr_rst=1, chan_fail=1. Exits only on reset or chan_en=0.
- qdr_rst=1 in every state except READY. chan_ready=1 only in READY.
- chan_en=0 in any state -> IDLE next cycle.
  - IDLE clears retry_cnt and chan_fail.
  - loss_count is preserved; only reset clears it.
- loss_count saturates at 2^LOSS_W-1.
- Counter widths are $clog2 of the largest of PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE, CTRL_RST_CYCLES, plus 1. One shared down/up counter per channel, reloaded on every state entry.
- Simultaneous events:
  - reset beats everything; chan_en=0 beats a lock event.
  - A lock drop in the same cycle the STABLE or CTRL_RST count completes takes priority; the lock-drop transition wins.
- Reset mid-sequence returns all outputs to reset values on the next edge; pll_rst reasserts immediately.
- Channels are fully independent. all_ready is registered, so it has 1 extra cycle of latency over chan_ready.

Decomposition:
- Package qdr_seq_pkg holds:
  - state encoding localparams: IDLE, PLL_RST, WAIT_LOCK, STABLE, CTRL_RST, READY, FAIL;
  - a counter-width function.
- Sub-module qdr_clk_rst_chan: one channel's synchronizer, FSM, counter and loss counter.
- The top generates NUM_CH instances and the all_ready reduction.

Test Plan:
- Bring-up:
  - Stimulus: NUM_CH=2, PLL_RST_CYCLES=4, LOCK_STABLE=8, CTRL_RST_CYCLES=4; chan_en=2'b11; pll_lock rises 10 cycles after pll_rst falls.
  - Required: pll_rst high exactly 4 cycles; qdr_rst low and chan_ready=1 exactly 2 (sync) + 8 + 4 + 1 cycles after lock rises; all_ready one cycle later.
- Timeout and fail:
  - Stimulus: LOCK_TIMEOUT=20, RETRY_LIMIT=3; pll_lock held at 0.
  - Required: exactly 3 pll_rst pulses, then chan_fail=1 and pll_rst stuck high; chan_en toggled 0->1 clears chan_fail and restarts.
- Glitch in STABLE:
  - Stimulus: lock drops for 1 cycle at stable count 5.
  - Required: no loss_count increment; STABLE restarts; chan_ready is delayed by the full LOCK_STABLE.
- Loss in READY:
  - Stimulus: drop ch1 lock while both channels are READY.
  - Required: ch1 qdr_rst=1, chan_ready[1]=0, loss_count[1]=1, all_ready=0; ch0 unaffected; ch1 re-sequences to READY.
- Saturation:
  - Stimulus: LOSS_W=2; 5 lock losses.
  - Required: loss_count=3.
- Reset mid-sequence:
  - Stimulus: assert reset during CTRL_RST.
  - Required: next cycle pll_rst=1, qdr_rst=1, loss_count=0, FSM in IDLE.
